// File: rtl/rdm_harq_combine.sv
// Consumer end of the RDM stream: writes (first tx) or saturating-combines
// (retx) 16-lane LLR beats into the HARQ soft buffer through a 3-stage pipeline.
module rdm_harq_combine #(
  parameter int unsigned LLR_WIDTH  = 6,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                    i_core_clk,
  input  logic                    i_rx_rst,
  input  logic                    i_combine_start,
  input  logic [15:0]             i_ncb_size,
  input  logic                    i_harq_first_tx,
  output logic                    o_rdm_data_request,
  input  logic                    i_rdm_data_valid,
  input  logic [16*LLR_WIDTH-1:0] i_rdm_data_content,
  output logic                    o_harq_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_harq_rd_addr,
  input  logic [16*LLR_WIDTH-1:0] i_harq_rd_data,
  output logic                    o_harq_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_harq_wr_addr,
  output logic [16*LLR_WIDTH-1:0] o_harq_wr_data,
  output logic                    o_combine_busy,
  output logic                    o_combine_done,
  output logic [15:0]             o_sat_count,
  output logic                    o_overrun
);

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = LANES * LLR_WIDTH;
  localparam int unsigned SW    = LLR_WIDTH + 1;
  localparam int unsigned KW    = 13;
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (LLR_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;
  logic   req_q, req_d, busy_q, busy_d, done_q, done_d;

  logic [KW-1:0]         n_q, k_q;
  logic [3:0]            rem_q;
  logic                  first_q;
  logic                  s1_vld_q, s1_last_q, s2_vld_q, s2_last_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
  logic [DW-1:0]         s1_data_q, s2_data_q;
  logic                  rd_en_q, wr_en_q, overrun_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DW-1:0]         wr_data_q;
  logic [15:0]           sat_q;

  logic start_acc, beat_acc, last_beat;
  assign start_acc = (state_q == S_IDLE) && i_combine_start;
  assign beat_acc  = (state_q == S_REQ) && i_rdm_data_valid;
  assign last_beat = beat_acc && (k_q == n_q - KW'(1));

  // State register
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = (i_ncb_size == 16'd0) ? S_DONE : S_REQ;
      S_REQ:   if (last_beat) state_d = S_DRAIN;
      S_DRAIN: if (s2_vld_q && s2_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // Lane combine and clamp; lanes past the remainder on the last beat are zeroed
  logic signed [SW-1:0] lane_in, lane_st, lane_sum;
  logic                 lane_mask;
  logic [DW-1:0]        comb_data;
  logic [4:0]           lane_cnt;
  always_comb begin
    comb_data = '0;
    lane_cnt  = '0;
    lane_in   = '0;
    lane_st   = '0;
    lane_sum  = '0;
    lane_mask = 1'b0;
    for (int m = 0; m < LANES; m++) begin
      lane_in = {s2_data_q[m*LLR_WIDTH + LLR_WIDTH - 1], s2_data_q[m*LLR_WIDTH +: LLR_WIDTH]};
      lane_st = first_q ? '0 :
                {i_harq_rd_data[m*LLR_WIDTH + LLR_WIDTH - 1], i_harq_rd_data[m*LLR_WIDTH +: LLR_WIDTH]};
      lane_sum  = lane_in + lane_st;
      lane_mask = s2_last_q && (rem_q != 4'd0) && (4'(m) >= rem_q);
      if (lane_mask) begin
        comb_data[m*LLR_WIDTH +: LLR_WIDTH] = '0;
      end else if (lane_sum > SAT_HI) begin
        comb_data[m*LLR_WIDTH +: LLR_WIDTH] = SAT_HI[LLR_WIDTH-1:0];
        lane_cnt = lane_cnt + 5'd1;
      end else if (lane_sum < SAT_LO) begin
        comb_data[m*LLR_WIDTH +: LLR_WIDTH] = SAT_LO[LLR_WIDTH-1:0];
        lane_cnt = lane_cnt + 5'd1;
      end else begin
        comb_data[m*LLR_WIDTH +: LLR_WIDTH] = lane_sum[LLR_WIDTH-1:0];
      end
    end
  end

  logic [16:0] sat_sum;
  assign sat_sum = {1'b0, sat_q} + 17'(lane_cnt);

  // Beat -> read issue -> read data -> write pipeline plus pass bookkeeping
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      n_q       <= '0;
      k_q       <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;

      if (start_acc) begin
        n_q     <= KW'(i_ncb_size[15:4]) + KW'(i_ncb_size[3:0] != 4'd0);
        rem_q   <= i_ncb_size[3:0];
        first_q <= i_harq_first_tx;
        k_q     <= '0;
      end else if (beat_acc) begin
        k_q <= k_q + KW'(1);
      end

      s1_vld_q  <= beat_acc;
      s1_last_q <= last_beat;
      rd_en_q   <= beat_acc && !first_q;
      if (beat_acc) begin
        s1_addr_q <= ADDR_WIDTH'(k_q);
        s1_data_q <= i_rdm_data_content;
      end

      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_addr_q <= s1_addr_q;
      s2_data_q <= s1_data_q;

      wr_en_q <= s2_vld_q;
      if (s2_vld_q) begin
        wr_addr_q <= s2_addr_q;
        wr_data_q <= comb_data;
      end

      if (start_acc)     sat_q <= '0;
      else if (s2_vld_q) sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

      if (i_rdm_data_valid && (state_q != S_REQ)) overrun_q <= 1'b1;
    end
  end

  assign o_rdm_data_request = req_q;
  assign o_combine_busy     = busy_q;
  assign o_combine_done     = done_q;
  assign o_harq_rd_en       = rd_en_q;
  assign o_harq_rd_addr     = s1_addr_q;
  assign o_harq_wr_en       = wr_en_q;
  assign o_harq_wr_addr     = wr_addr_q;
  assign o_harq_wr_data     = wr_data_q;
  assign o_sat_count        = sat_q;
  assign o_overrun          = overrun_q;

endmodule

// File: tb/tb_rdm_harq_combine.sv
// Scoreboard bench for rdm_harq_combine: directed passes push expected RAM
// strobes and done pulses; a forked monitor pops and compares them cycle-exactly.
module tb_rdm_harq_combine;

  logic        clk, rst, start, first, req, valid;
  logic [15:0] ncb, sat;
  logic [95:0] data, rd_data, wr_data;
  logic        rd_en, wr_en, busy, done, overrun;
  logic [11:0] rd_addr, wr_addr;
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [95:0] pre_val;
  logic [95:0] mem [4096];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct { int cyc; logic [11:0] addr; logic [95:0] data; } wr_exp_t;
  typedef struct { int cyc; logic [11:0] addr; } rd_exp_t;
  wr_exp_t exp_wr[$];
  rd_exp_t exp_rd[$];
  int      exp_done[$];

  rdm_harq_combine dut (
    .i_core_clk(clk), .i_rx_rst(rst), .i_combine_start(start), .i_ncb_size(ncb),
    .i_harq_first_tx(first), .o_rdm_data_request(req), .i_rdm_data_valid(valid),
    .i_rdm_data_content(data), .o_harq_rd_en(rd_en), .o_harq_rd_addr(rd_addr),
    .i_harq_rd_data(rd_data), .o_harq_wr_en(wr_en), .o_harq_wr_addr(wr_addr),
    .o_harq_wr_data(wr_data), .o_combine_busy(busy), .o_combine_done(done),
    .o_sat_count(sat), .o_overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // HARQ RAM model with 1-cycle read latency and a bench-side preload port
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: strobe with nothing expected (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [95:0] word(input logic [5:0] v, input int nl);
    logic [95:0] w;
    w = '0;
    for (int m = 0; m < 16; m++) if (m < nl) w[m*6 +: 6] = v;
    return w;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rd_en) begin
        if (exp_rd.size() == 0) unexpected("rd_en");
        else begin
          rd_exp_t r;
          r = exp_rd.pop_front();
          chk("rd_addr", 96'(rd_addr), 96'(r.addr));
          chk("rd_cycle", 96'(cyc), 96'(r.cyc));
        end
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) unexpected("wr_en");
        else begin
          wr_exp_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", 96'(wr_addr), 96'(w.addr));
          chk("wr_data", wr_data, w.data);
          chk("wr_cycle", 96'(cyc), 96'(w.cyc));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done");
        else chk("done_cycle", 96'(cyc), 96'(exp_done.pop_front()));
      end
    end
  endtask

  task automatic preload(input int cnt, input logic [5:0] v);
    for (int a = 0; a < cnt; a++) begin
      pre_en = 1'b1; pre_addr = 12'(a); pre_val = {16{v}};
      @(negedge clk);
    end
    pre_en = 1'b0;
  endtask

  task automatic start_pass(input logic [15:0] n, input logic f);
    start = 1'b1; ncb = n; first = f;
    if (n == 16'd0) exp_done.push_back(cyc + 2);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [5:0] v, input logic [5:0] ev, input int addr, input int nl,
                      input bit comb, input bit last, input int gap);
    int      e;
    wr_exp_t w;
    e = cyc + 1;
    valid = 1'b1;
    data  = {16{v}};
    if (comb) exp_rd.push_back('{cyc: e, addr: 12'(addr)});
    w.cyc = e + 2; w.addr = 12'(addr); w.data = word(ev, nl);
    exp_wr.push_back(w);
    if (last) exp_done.push_back(e + 3);
    @(negedge clk);
    if (gap > 0) begin
      valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input logic [15:0] exp_sat);
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 96'(exp_done.size()), 96'd0);
    @(negedge clk);
    chk("sat_count", 96'(sat), 96'(exp_sat));
    chk("busy_after", 96'(busy), 96'd0);
  endtask

  task automatic run_pass(input logic [15:0] n, input logic f, input logic [5:0] v,
                          input logic [5:0] ev, input int gap, input logic [15:0] exp_sat);
    int nb, rem;
    nb  = (int'(n) + 15) / 16;
    rem = int'(n) % 16;
    start_pass(n, f);
    chk("req_on", 96'(req), 96'd1);
    chk("busy_on", 96'(busy), 96'd1);
    for (int k = 0; k < nb; k++)
      beat(v, ev, k, (k == nb - 1 && rem != 0) ? rem : 16, !f, k == nb - 1, gap);
    valid = 1'b0;
    wait_done(exp_sat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ncb = '0; first = 1'b0; valid = 1'b0; data = '0;
    pre_en = 1'b0; pre_addr = '0; pre_val = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_req", 96'(req), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_rd_en", 96'(rd_en), 96'd0);
    chk("rst_wr_en", 96'(wr_en), 96'd0);
    chk("rst_wr_data", wr_data, 96'd0);
    chk("rst_sat", 96'(sat), 96'd0);
    chk("rst_overrun", 96'(overrun), 96'd0);
    rst = 1'b0;
    @(negedge clk);

    // First tx, plain copy and -32 clamp
    run_pass(16'd32, 1'b1, 6'd5, 6'd5, 0, 16'd0);
    chk("overrun_clear", 96'(overrun), 96'd0);
    run_pass(16'd16, 1'b1, 6'h20, 6'h21, 0, 16'd16);

    // Combine: positive clamp, cancel to zero, negative clamp
    preload(1, 6'd20);
    run_pass(16'd16, 1'b0, 6'd20, 6'h1F, 0, 16'd16);
    preload(1, 6'd20);
    run_pass(16'd16, 1'b0, 6'h2C, 6'h00, 0, 16'd0);
    preload(1, 6'h21);
    run_pass(16'd16, 1'b0, 6'h3F, 6'h21, 0, 16'd16);

    // Partial last beat (R = 3), then gapped valid
    preload(3, 6'd1);
    run_pass(16'd35, 1'b0, 6'd1, 6'd2, 0, 16'd0);
    preload(3, 6'd3);
    run_pass(16'd48, 1'b0, 6'd4, 6'd7, 2, 16'd0);

    // Empty pass; a second start during DONE must be ignored
    start_pass(16'd0, 1'b1);
    chk("zero_busy", 96'(busy), 96'd1);
    chk("zero_req", 96'(req), 96'd0);
    start = 1'b1; ncb = 16'd16; first = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_start_busy", 96'(busy), 96'd0);
    chk("ignored_start_req", 96'(req), 96'd0);
    chk("zero_done_seen", 96'(exp_done.size()), 96'd0);

    // Beat in IDLE sets sticky overrun
    valid = 1'b1; data = {16{6'd9}};
    @(negedge clk);
    valid = 1'b0;
    chk("overrun_set", 96'(overrun), 96'd1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", 96'(overrun), 96'd1);

    // Reset in the middle of REQ
    start_pass(16'd32, 1'b1);
    chk("req_before_rst", 96'(req), 96'd1);
    valid = 1'b1; data = {16{6'd7}}; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 96'(req), 96'd0);
    chk("mid_rst_busy", 96'(busy), 96'd0);
    chk("mid_rst_rd_en", 96'(rd_en), 96'd0);
    chk("mid_rst_wr_en", 96'(wr_en), 96'd0);
    chk("mid_rst_overrun", 96'(overrun), 96'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 96'(busy), 96'd0);
    chk("post_rst_req", 96'(req), 96'd0);

    chk("wr_queue_empty", 96'(exp_wr.size()), 96'd0);
    chk("rd_queue_empty", 96'(exp_rd.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
